// File: rtl/instr_byte_aligner_pkg.sv
// Shared constants and types for the instruction byte aligner and its rotator.
package instr_byte_aligner_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int RING_BYTES     = 2 * LINE_BYTES;
    localparam int MAX_INSN_BYTES = 15;

    // Byte-lane index into the 32-byte ring; arithmetic wraps mod 32 for free.
    typedef logic [4:0] lane_idx_t;
    typedef logic [5:0] byte_count_t;

endpackage

// File: rtl/instr_byte_aligner_rotate.sv
// byte_rotate32x16: combinational selector of 16 consecutive bytes (mod 32) from a
// 32-byte source, starting at lane sel. Used for both read-window and write steering.
module byte_rotate32x16
    import instr_byte_aligner_pkg::*;
(
    input  logic [8*RING_BYTES-1:0] src,
    input  lane_idx_t               sel,
    output logic [8*LINE_BYTES-1:0] dst
);

    for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
        lane_idx_t idx;
        assign idx = sel + lane_idx_t'(gi);
        assign dst[8*gi +: 8] = src[{idx, 3'b000} +: 8];
    end

endmodule

// File: rtl/instr_byte_aligner.sv
// Fetch-side instruction byte queue: 32-byte ring presenting a 16-byte decode window.
// Optional INSTR_ALIGNER_STALL_CNT_EN adds a saturating stall_cycles counter output.
module instr_byte_aligner
    import instr_byte_aligner_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_valid,
    output logic                    fetch_ready,
    input  logic [8*LINE_BYTES-1:0] fetch_line,
    input  logic [3:0]              fetch_offset,
    input  logic                    flush,
    output logic [8*LINE_BYTES-1:0] window,
    output logic                    window_valid,
    input  logic                    consume_valid,
    input  logic [3:0]              consume_len,
    output logic                    consume_err
`ifdef INSTR_ALIGNER_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cycles
`endif
);

    logic [7:0]  ring_reg [RING_BYTES];
    lane_idx_t   head_reg, head_next;
    lane_idx_t   tail_reg, tail_next;
    byte_count_t count_reg, count_next;
    logic        err_reg, err_next;

    logic [4:0]              push_len;
    logic                    push_fire;
    logic                    consume_ok;
    logic                    consume_fire;
    logic                    consume_bad;
    logic [8*RING_BYTES-1:0] ring_flat;
    logic [8*RING_BYTES-1:0] line_dup;
    logic [8*LINE_BYTES-1:0] line_shift;
    logic [8*LINE_BYTES-1:0] window_raw;
    logic [RING_BYTES-1:0]   wr_en;
    logic [8*RING_BYTES-1:0] wr_data;

    // Status comes only from registered count, so consume_* never reaches these outputs.
    assign window_valid = (count_reg >= byte_count_t'(LINE_BYTES));
    assign fetch_ready  = (count_reg <= byte_count_t'(LINE_BYTES)) && !flush;
    assign consume_err  = err_reg;

    assign push_len     = 5'd16 - {1'b0, fetch_offset};
    assign push_fire    = fetch_valid && fetch_ready;
    assign consume_ok   = window_valid && (consume_len != 4'd0)
                          && ({1'b0, consume_len} <= 5'(MAX_INSN_BYTES));
    assign consume_fire = consume_valid && !flush && consume_ok;
    assign consume_bad  = consume_valid && !flush && !consume_ok;

    // Write steering: rotate the line so its first kept byte lands in lane 0,
    // then each ring slot picks its lane by distance from tail.
    assign line_dup = {fetch_line, fetch_line};

    byte_rotate32x16 u_write_rotate (
        .src (line_dup),
        .sel ({1'b0, fetch_offset}),
        .dst (line_shift)
    );

    for (genvar gi = 0; gi < RING_BYTES; gi++) begin : g_slot
        lane_idx_t rel;
        assign rel                 = lane_idx_t'(gi) - tail_reg;
        assign wr_en[gi]           = push_fire && (rel < push_len);
        assign wr_data[8*gi +: 8]  = line_shift[{rel[3:0], 3'b000} +: 8];
        assign ring_flat[8*gi +: 8] = ring_reg[gi];
    end

    byte_rotate32x16 u_read_rotate (
        .src (ring_flat),
        .sel (head_reg),
        .dst (window_raw)
    );

    // Ring storage is never cleared, so stale bytes are hidden when empty.
    assign window = (count_reg == '0) ? '0 : window_raw;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        err_next   = err_reg || consume_bad;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push_fire) begin
                tail_next = tail_reg + push_len;
            end
            if (consume_fire) begin
                head_next = head_reg + {1'b0, consume_len};
            end
            count_next = count_reg
                       + (push_fire    ? {1'b0, push_len}    : byte_count_t'(0))
                       - (consume_fire ? {2'b0, consume_len} : byte_count_t'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < RING_BYTES; j++) begin
            if (wr_en[j]) begin
                ring_reg[j] <= wr_data[8*j +: 8];
            end
        end
    end

`ifdef INSTR_ALIGNER_STALL_CNT_EN
    logic [15:0] stall_reg;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            stall_reg <= '0;
        end else if (!window_valid && (stall_reg != 16'hFFFF)) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_instr_byte_aligner.sv
// Self-checking bench for instr_byte_aligner: constant vector table, hand sequences,
// and a byte-stream reference model feeding a scoreboard of expected outputs.
module tb_instr_byte_aligner;

    logic         clk = 1'b0;
    logic         reset;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [127:0] fetch_line;
    logic [3:0]   fetch_offset;
    logic         flush;
    logic [127:0] window;
    logic         window_valid;
    logic         consume_valid;
    logic [3:0]   consume_len;
    logic         consume_err;
`ifdef INSTR_ALIGNER_STALL_CNT_EN
    logic [15:0]  stall_cycles;
`endif

    always #5 clk = ~clk;

    instr_byte_aligner dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_line    (fetch_line),
        .fetch_offset  (fetch_offset),
        .flush         (flush),
        .window        (window),
        .window_valid  (window_valid),
        .consume_valid (consume_valid),
        .consume_len   (consume_len),
        .consume_err   (consume_err)
`ifdef INSTR_ALIGNER_STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         wv;
        logic         fr;
        logic         err;
        logic         chk_win;
        logic [127:0] win;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mq[$];
    logic       m_err;

    typedef struct {
        logic       fv;
        logic [7:0] base;
        logic [3:0] off;
        logic       fl;
        logic       cv;
        logic [3:0] len;
        logic       e_wv;
        logic       e_fr;
        logic       e_err;
        logic       chk_b0;
        logic       chk_b15;
        logic [7:0] e_b0;
        logic [7:0] e_b15;
    } vec_t;

    vec_t tbl[9];

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] make_line(input logic [7:0] base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
        return l;
    endfunction

    task automatic idle();
        fetch_valid   = 1'b0;
        fetch_line    = '0;
        fetch_offset  = '0;
        flush         = 1'b0;
        consume_valid = 1'b0;
        consume_len   = '0;
    endtask

    // Reference model: the ring is a queue of buffered stream bytes.
    task automatic model_step(input logic fv, input logic [127:0] line, input logic [3:0] off,
                              input logic fl, input logic cv, input logic [3:0] len);
        exp_t e;
        int   sz;
        if (fl) begin
            mq.delete();
        end else begin
            sz = mq.size();
            if (cv && !(sz >= 16 && len != 0)) m_err = 1'b1;
            if (fv && sz <= 16) begin
                for (int i = int'(off); i < 16; i++) mq.push_back(line[8*i +: 8]);
            end
            if (cv && sz >= 16 && len != 0) begin
                repeat (int'(len)) void'(mq.pop_front());
            end
        end
        e.wv      = (mq.size() >= 16);
        e.fr      = (mq.size() <= 16);
        e.err     = m_err;
        e.chk_win = (mq.size() >= 16) || (mq.size() == 0);
        e.win     = '0;
        if (mq.size() >= 16) begin
            for (int i = 0; i < 16; i++) e.win[8*i +: 8] = mq[i];
        end
        sbq.push_back(e);
    endtask

    task automatic cycle(input logic fv, input logic [127:0] line, input logic [3:0] off,
                         input logic fl, input logic cv, input logic [3:0] len);
        fetch_valid   = fv;
        fetch_line    = line;
        fetch_offset  = off;
        flush         = fl;
        consume_valid = cv;
        consume_len   = len;
        model_step(fv, line, off, fl, cv, len);
        @(posedge clk);
        #1 idle();
        #1;
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty actual=none required=entry", tag);
            return;
        end
        total--;
        e = sbq.pop_front();
        check_val({tag, "_sb_wv"},  {127'd0, window_valid}, {127'd0, e.wv});
        check_val({tag, "_sb_fr"},  {127'd0, fetch_ready},  {127'd0, e.fr});
        check_val({tag, "_sb_err"}, {127'd0, consume_err},  {127'd0, e.err});
        if (e.chk_win) check_val({tag, "_sb_win"}, window, e.win);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        mq.delete();
        sbq.delete();
        m_err = 1'b0;
        check_val("reset_fr",  {127'd0, fetch_ready},  128'd1);
        check_val("reset_wv",  {127'd0, window_valid}, 128'd0);
        check_val("reset_win", window,                 128'd0);
        check_val("reset_err", {127'd0, consume_err},  128'd0);
    endtask

    initial begin
        logic [127:0] line;
        logic [7:0]   sp;
        logic [3:0]   off;
        logic [3:0]   len;
        logic         fl;
        logic         cv;
        string        tag;
        int           ninstr;

        //             fv   base   off  fl   cv   len  wv   fr   err  cb0  cb15 b0     b15
        tbl[0] = '{1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h0F};
        tbl[1] = '{1'b1, 8'h10, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h0F};
        tbl[2] = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 8'h12};
        tbl[3] = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00};
        tbl[4] = '{1'b1, 8'h00, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00};
        tbl[5] = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h05, 8'h00};
        tbl[6] = '{1'b1, 8'h10, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 8'h14};
        tbl[7] = '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 4'd11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 8'h1F};
        tbl[8] = '{1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00};

        reset = 1'b1;
        idle();
        do_reset();

        for (int v = 0; v < 9; v++) begin
            tag = $sformatf("vec%0d", v);
            cycle(tbl[v].fv, make_line(tbl[v].base), tbl[v].off, tbl[v].fl, tbl[v].cv, tbl[v].len);
            check_val({tag, "_wv"},  {127'd0, window_valid}, {127'd0, tbl[v].e_wv});
            check_val({tag, "_fr"},  {127'd0, fetch_ready},  {127'd0, tbl[v].e_fr});
            check_val({tag, "_err"}, {127'd0, consume_err},  {127'd0, tbl[v].e_err});
            if (tbl[v].chk_b0)  check_val({tag, "_b0"},  {120'd0, window[7:0]},    {120'd0, tbl[v].e_b0});
            if (tbl[v].chk_b15) check_val({tag, "_b15"}, {120'd0, window[127:120]}, {120'd0, tbl[v].e_b15});
            sb_compare(tag);
            $display("vec%0d fv=%0b fl=%0b cv=%0b len=%0d -> wv=%0b fr=%0b err=%0b b0=%h",
                     v, tbl[v].fv, tbl[v].fl, tbl[v].cv, tbl[v].len,
                     window_valid, fetch_ready, consume_err, window[7:0]);
        end

        // Push and consume arriving together with flush are dropped, not flagged.
        do_reset();
        cycle(1'b1, make_line(8'h40), 4'd0, 1'b0, 1'b0, 4'd0);
        sb_compare("flush_pre");
        cycle(1'b1, make_line(8'h80), 4'd0, 1'b1, 1'b1, 4'd4);
        check_val("flush_drop_wv",  {127'd0, window_valid}, 128'd0);
        check_val("flush_drop_err", {127'd0, consume_err},  128'd0);
        check_val("flush_drop_win", window,                 128'd0);
        sb_compare("flush_drop");
        cycle(1'b1, make_line(8'h50), 4'd0, 1'b0, 1'b0, 4'd0);
        check_val("after_flush_b0", {120'd0, window[7:0]}, {120'd0, 8'h50});
        sb_compare("after_flush");
        cycle(1'b0, '0, 4'd0, 1'b0, 1'b1, 4'd0);
        check_val("len0_err", {127'd0, consume_err},  128'd1);
        check_val("len0_b0",  {120'd0, window[7:0]},  {120'd0, 8'h50});
        sb_compare("len0");
        $display("flush/len0 sequence: wv=%0b err=%0b b0=%h", window_valid, consume_err, window[7:0]);

        // Continuous fetch with length-7 consumes, wrapping the ring several times.
        do_reset();
        sp = 8'h00;
        ninstr = 0;
        for (int c = 0; c < 60; c++) begin
            line = make_line(sp);
            cv = (mq.size() >= 16);
            if (mq.size() <= 16) sp = sp + 8'd16;
            if (cv) ninstr++;
            cycle(1'b1, line, 4'd0, 1'b0, cv, 4'd7);
            sb_compare($sformatf("wrap%0d", c));
            $display("wrap%0d cv=%0b wv=%0b b0=%h err=%0b", c, cv, window_valid, window[7:0], consume_err);
        end
        check_val("wrap_no_err", {127'd0, consume_err}, 128'd0);

        // Random offsets, lengths, occasional flush and stray consumes.
        do_reset();
        sp = 8'h00;
        for (int c = 0; c < 200; c++) begin
            off = 4'($urandom_range(0, 15));
            len = 4'($urandom_range(1, 15));
            fl  = ($urandom_range(0, 29) == 0);
            cv  = (mq.size() >= 16) || ($urandom_range(0, 39) == 0);
            for (int i = 0; i < 16; i++) begin
                line[8*i +: 8] = (i >= int'(off)) ? (sp + 8'(i - int'(off))) : (8'hEE ^ 8'(i));
            end
            if (!fl && mq.size() <= 16) sp = sp + (8'd16 - {4'd0, off});
            cycle(1'b1, line, off, fl, cv, len);
            sb_compare($sformatf("rnd%0d", c));
            $display("rnd%0d off=%0d len=%0d fl=%0b cv=%0b wv=%0b b0=%h err=%0b",
                     c, off, len, fl, cv, window_valid, window[7:0], consume_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
